fetch_buffer: RTL and testbench
===============================

// Module: fetch_buffer
// PURPOSE
//   Instruction-fetch stage that sits directly upstream of instruction_decoder.
//   Owns the fetch PC, drives instruction_memory's read address and captures
//   each fetched word with its address into a small in-order queue.
//   Presents the queue head to decode with a valid/ready handshake.
//   A redirect flushes the queue and restarts fetch at a new address
//   (taken branch; target computed downstream).
// PARAMETERS
//   ADDR_W   4    instruction address width; PC wraps modulo 2**ADDR_W
//   INSTR_W  16   instruction word width
//   DEPTH    4    queue entries; power of 2, >= 2
// PORTS
//   clk          in   1                    rising-edge clock
//   rst          in   1                    synchronous, active-high reset
//   imem_addr    out  ADDR_W               read address to instruction_memory (combinational read)
//   imem_instr   in   INSTR_W              word returned for imem_addr in the same cycle
//   fetch_en     in   1                    1 = fetch allowed this cycle
//   redirect     in   1                    flush queue and restart fetch at redirect_pc
//   redirect_pc  in   ADDR_W               restart address, sampled when redirect=1
//   out_valid    out  1                    queue head valid
//   out_ready    in   1                    decode accepts head this cycle
//   out_instr    out  INSTR_W              head instruction (show-ahead)
//   out_pc       out  ADDR_W               address of head instruction
//   count        out  $clog2(DEPTH)+1      occupied entries, 0..DEPTH
//   full         out  1                    count == DEPTH
// BEHAVIOUR
//   - Reset, synchronous on the clk edge with rst=1:
//     fetch_pc=0, queue empty, count=0, out_valid=0, full=0.
//     out_instr/out_pc are don't-care while out_valid=0.
//   - imem_addr = fetch_pc, combinationally, in every cycle.
//   - pop = out_valid & out_ready.
//   - push = fetch_en & !redirect & (count<DEPTH | pop).
//     A push writes {imem_instr, fetch_pc} at the tail.
//     fetch_pc <= fetch_pc+1, wrapping 2**ADDR_W-1 -> 0.
//   - Push and pop in the same cycle: count is unchanged.
//     A push into a full queue is legal only with a simultaneous pop.
//   - Latency: a word pushed at edge N is visible as head after edge N, if the
//     queue was empty. There is no bypass: out_valid is never set combinationally
//     from imem_instr.
//   - After rst falls, the first edge pushes PC 0, so out_valid=1 one cycle later.
//     With out_ready held at 1, throughput is 1 instruction per cycle.
//   - Redirect (rst=0, redirect=1) at an edge:
//     all entries are discarded, count=0, fetch_pc <= redirect_pc, no push.
//     A head transferred in the same cycle (pop) counts as delivered; decode
//     discards it.
//     out_valid=0 for exactly one cycle; the next head has out_pc=redirect_pc.
//   - Priority: rst > redirect > push/pop.
//   - Reset asserted mid-stream behaves as a redirect to PC 0 and also clears
//     the pointers.
//   - fetch_en=0: fetch_pc and imem_addr hold, the queue keeps draining via pop,
//     and redirect still applies.
//   - Queue order is strict FIFO; each fetched address is delivered exactly once
//     unless flushed.
//   - Pointers are log2(DEPTH) bits and wrap naturally; full/empty are derived
//     from count.
// TESTING  (imem model: imem_instr = 16'hA000 | imem_addr)
//   1. rst 1 cycle, then fetch_en=1, out_ready=1 -> out_pc 0,1,..,15,0,1
//      back-to-back, out_instr=16'hA000|out_pc; first out_valid one cycle
//      after rst falls.
//   2. out_ready=0 for 8 cycles -> count=4, full=1, imem_addr holds 4; then
//      out_ready=1 -> out_pc 0,1,2,3,4,5 with no gaps or duplicates.
//   3. 3 entries queued, redirect=1, redirect_pc=9 for 1 cycle -> next cycle
//      count=0, out_valid=0; the cycle after: out_valid=1, out_pc=9,
//      out_instr=16'hA009.
//   4. redirect=1 (redirect_pc=7) and rst=1 in the same cycle -> reset wins;
//      the first post-reset out_pc=0.
//   5. fetch_en=0 with out_ready=1 and 4 entries -> the queue drains to
//      count=0, out_valid=0; imem_addr is constant throughout.
//   6. Redirect to 14 with out_ready=1 -> out_pc 14,15,0,1 (wrap); push and pop
//      together while full keep count=4.

Source files
------------

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - instruction fetch stage: owns the fetch PC, queues fetched words for decode
module fetch_buffer #(
  parameter int ADDR_W  = 4,
  parameter int INSTR_W = 16,
  parameter int DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic [ADDR_W-1:0]          imem_addr,
  input  logic [INSTR_W-1:0]         imem_instr,
  input  logic                       fetch_en,
  input  logic                       redirect,
  input  logic [ADDR_W-1:0]          redirect_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [INSTR_W-1:0]         out_instr,
  output logic [ADDR_W-1:0]          out_pc,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0]  fetch_pc;
  logic [INSTR_W-1:0] instr_q [DEPTH];
  logic [ADDR_W-1:0]  pc_q    [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   cnt;
  logic               push;
  logic               pop;

  assign imem_addr = fetch_pc;

  // Head visibility comes only from the registered count, never from imem_instr.
  assign out_valid = (cnt != '0);
  assign full      = (cnt == CNT_W'(DEPTH));
  assign count     = cnt;
  assign out_instr = instr_q[rd_ptr];
  assign out_pc    = pc_q[rd_ptr];

  assign pop  = out_valid & out_ready;
  assign push = fetch_en & ~redirect & ~rst & ((cnt < CNT_W'(DEPTH)) | pop);

  always_ff @(posedge clk) begin
    if (push) begin
      instr_q[wr_ptr] <= imem_instr;
      pc_q[wr_ptr]    <= fetch_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
    end else if (redirect) begin
      // A head popped this cycle still counts as delivered; everything else is dropped.
      fetch_pc <= redirect_pc;
      rd_ptr   <= wr_ptr;
      cnt      <= '0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + PTR_W'(1);
        fetch_pc <= fetch_pc + ADDR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        cnt <= cnt + CNT_W'(1);
      end else if (pop && !push) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// tb/tb_fetch_buffer.sv - directed self-checking bench for fetch_buffer
module tb_fetch_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  imem_addr;
  logic [15:0] imem_instr;
  logic        fetch_en = 1'b0;
  logic        redirect = 1'b0;
  logic [3:0]  redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_instr;
  logic [3:0]  out_pc;
  logic [2:0]  count;
  logic        full;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  assign imem_instr = 16'hA000 | {12'h000, imem_addr};

  fetch_buffer #(.ADDR_W(4), .INSTR_W(16), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .fetch_en(fetch_en), .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .count(count), .full(full)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one rising edge; inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    // Test 1: reset state, then back-to-back streaming with PC wrap
    rst = 1'b1; fetch_en = 1'b1; out_ready = 1'b1;
    step();
    check("reset_count", 32'(count), 0);
    check("reset_valid", 32'(out_valid), 0);
    check("reset_full", 32'(full), 0);
    check("reset_addr", 32'(imem_addr), 0);
    rst = 1'b0;
    step();
    for (int i = 0; i < 18; i++) begin
      check("t1_valid", 32'(out_valid), 1);
      check("t1_pc", 32'(out_pc), 32'(i % 16));
      check("t1_instr", 32'(out_instr), 32'h0000A000 | 32'(i % 16));
      step();
    end

    // Test 2: back-pressure fills the queue, then drains in order
    out_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 8; i++) step();
    check("t2_count", 32'(count), 4);
    check("t2_full", 32'(full), 1);
    check("t2_addr", 32'(imem_addr), 4);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check("t2_pc", 32'(out_pc), 32'(i));
      check("t2_count_steady", 32'(count), 4);
      step();
    end

    // Test 3: redirect with three entries queued
    out_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 3; i++) step();
    check("t3_count_pre", 32'(count), 3);
    redirect = 1'b1; redirect_pc = 4'd9;
    step();
    redirect = 1'b0;
    check("t3_count_flush", 32'(count), 0);
    check("t3_valid_flush", 32'(out_valid), 0);
    step();
    check("t3_valid", 32'(out_valid), 1);
    check("t3_pc", 32'(out_pc), 9);
    check("t3_instr", 32'(out_instr), 32'h0000A009);

    // Test 4: reset beats redirect
    rst = 1'b1; redirect = 1'b1; redirect_pc = 4'd7;
    step();
    rst = 1'b0; redirect = 1'b0; out_ready = 1'b1;
    check("t4_count", 32'(count), 0);
    check("t4_addr", 32'(imem_addr), 0);
    step();
    check("t4_valid", 32'(out_valid), 1);
    check("t4_pc", 32'(out_pc), 0);

    // Test 5: fetch disabled, queue drains, fetch PC holds
    out_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) step();
    check("t5_count_full", 32'(count), 4);
    fetch_en = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t5_drain_count", 32'(count), 32'(4 - i));
      check("t5_drain_pc", 32'(out_pc), 32'(i));
      check("t5_addr_hold", 32'(imem_addr), 4);
      step();
    end
    check("t5_count_empty", 32'(count), 0);
    check("t5_valid_empty", 32'(out_valid), 0);
    check("t5_addr_final", 32'(imem_addr), 4);

    // Test 6: redirect near the top of the address space, wrap, full push+pop
    fetch_en = 1'b1; redirect = 1'b1; redirect_pc = 4'd14;
    step();
    redirect = 1'b0;
    check("t6_valid_gap", 32'(out_valid), 0);
    step();
    for (int i = 0; i < 4; i++) begin
      check("t6_pc_wrap", 32'(out_pc), 32'((14 + i) % 16));
      if (i == 3) out_ready = 1'b0;
      step();
    end
    for (int i = 0; i < 3; i++) step();
    check("t6_full", 32'(full), 1);
    check("t6_count", 32'(count), 4);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("t6_pc_full", 32'(out_pc), 32'(1 + i));
      check("t6_count_full", 32'(count), 4);
      step();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
